// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: a Moore FSM that sequences each instruction
// over 3-5 clocks and drives the shared-ALU/shared-memory datapath.
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   opcode, funct      instruction register fields IR[31:26], IR[5:0]
//   zero               ALU zero flag (branch decision)
//   mem_ready          memory access completes this cycle (used when MEM_WAIT=1)
//   pcen .. alucontrol datapath enables and mux selects (combinational from state)
//   sign               1 = sign-extend imm16, 0 = zero-extend
//   illegal            one-cycle pulse in DECODE for an unsupported instruction
//   state              current state encoding, for debug
module mc_controller #(
  parameter bit MEM_WAIT = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pcen,
  output logic       irwrite,
  output logic       iord,
  output logic       memwrite,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       sign,
  output logic       illegal,
  output logic [3:0] state
);

  localparam int unsigned OPW = 6;
  localparam int unsigned ALUW = 3;

  localparam logic [OPW-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPW-1:0] OP_LW    = 6'b100011;
  localparam logic [OPW-1:0] OP_SW    = 6'b101011;
  localparam logic [OPW-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPW-1:0] OP_BNE   = 6'b000101;
  localparam logic [OPW-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPW-1:0] OP_SLTI  = 6'b001010;
  localparam logic [OPW-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OPW-1:0] OP_ORI   = 6'b001101;
  localparam logic [OPW-1:0] OP_J     = 6'b000010;

  localparam logic [ALUW-1:0] ALU_AND = 3'b000;
  localparam logic [ALUW-1:0] ALU_OR  = 3'b001;
  localparam logic [ALUW-1:0] ALU_ADD = 3'b010;
  localparam logic [ALUW-1:0] ALU_SUB = 3'b110;
  localparam logic [ALUW-1:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTEX   = 4'd6,
    S_RTWB   = 4'd7,
    S_BRANCH = 4'd8,
    S_IMMEX  = 4'd9,
    S_IMMWB  = 4'd10,
    S_JUMP   = 4'd11
  } state_e;

  state_e state_q, state_d;

  logic                 ready;
  logic                 pcwrite;
  logic                 branch;
  logic                 branchne;
  logic                 rt_ok;
  logic [ALUW-1:0]      rt_alu;
  logic [ALUW-1:0]      imm_alu;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next state and datapath controls.
  always_comb begin
    state_d    = S_FETCH;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    irwrite    = 1'b0;
    iord       = 1'b0;
    memwrite   = 1'b0;
    regwrite   = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    alucontrol = ALU_ADD;
    illegal    = 1'b0;

    ready    = mem_ready | ~MEM_WAIT;
    branchne = (opcode == OP_BNE);
    sign     = ~((opcode == OP_ANDI) | (opcode == OP_ORI));

    // R-type function decode; rt_ok qualifies the funct as supported.
    rt_ok  = 1'b1;
    rt_alu = ALU_ADD;
    case (funct)
      6'b100000: rt_alu = ALU_ADD;
      6'b100010: rt_alu = ALU_SUB;
      6'b100100: rt_alu = ALU_AND;
      6'b100101: rt_alu = ALU_OR;
      6'b101010: rt_alu = ALU_SLT;
      default:   rt_ok  = 1'b0;
    endcase

    imm_alu = ALU_ADD;
    case (opcode)
      OP_SLTI: imm_alu = ALU_SLT;
      OP_ANDI: imm_alu = ALU_AND;
      OP_ORI:  imm_alu = ALU_OR;
      default: imm_alu = ALU_ADD;
    endcase

    case (state_q)
      S_FETCH: begin
        alusrcb = 2'b01;
        irwrite = ready;
        pcwrite = ready;
        state_d = ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        case (opcode)
          OP_LW, OP_SW:                      state_d = S_MEMADR;
          OP_BEQ, OP_BNE:                    state_d = S_BRANCH;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: state_d = S_IMMEX;
          OP_J:                              state_d = S_JUMP;
          OP_RTYPE: begin
            state_d = rt_ok ? S_RTEX : S_FETCH;
            illegal = ~rt_ok;
          end
          default: illegal = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord    = 1'b1;
        state_d = ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
        state_d  = ready ? S_FETCH : S_MEMWR;
      end
      S_RTEX: begin
        alusrca    = 1'b1;
        alucontrol = rt_alu;
        state_d    = S_RTWB;
      end
      S_RTWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
      end
      S_BRANCH: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = 2'b01;
        branch     = 1'b1;
      end
      S_IMMEX: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        alucontrol = imm_alu;
        state_d    = S_IMMWB;
      end
      S_IMMWB: regwrite = 1'b1;
      S_JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase

    // Reset suppresses every side effect, including a pending write.
    if (reset) begin
      state_d    = S_FETCH;
      pcwrite    = 1'b0;
      branch     = 1'b0;
      irwrite    = 1'b0;
      iord       = 1'b0;
      memwrite   = 1'b0;
      regwrite   = 1'b0;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = 2'b00;
      pcsrc      = 2'b00;
      alucontrol = ALU_ADD;
      illegal    = 1'b0;
    end
  end

  assign pcen  = pcwrite | (branch & (zero ^ branchne));
  assign state = 4'(state_q);

endmodule

// File: tb/tb_mc_controller.sv
// Randomized bench for mc_controller: one instance without and one with the
// memory-ready handshake, each checked every cycle against an instruction-level
// model (per-class state sequences plus wait/reset rules).
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset     [2];
  logic [5:0] opcode    [2];
  logic [5:0] funct     [2];
  logic       zero      [2];
  logic       mem_ready [2];
  logic       pcen [2], irwrite [2], iord [2], memwrite [2], regwrite [2];
  logic       regdst [2], memtoreg [2], alusrca [2], sign [2], illegal [2];
  logic [1:0] alusrcb [2], pcsrc [2];
  logic [2:0] alucontrol [2];
  logic [3:0] state [2];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mc_controller #(.MEM_WAIT(1'b0)) u_dut0 (
    .clk(clk), .reset(reset[0]), .opcode(opcode[0]), .funct(funct[0]),
    .zero(zero[0]), .mem_ready(mem_ready[0]), .pcen(pcen[0]), .irwrite(irwrite[0]),
    .iord(iord[0]), .memwrite(memwrite[0]), .regwrite(regwrite[0]), .regdst(regdst[0]),
    .memtoreg(memtoreg[0]), .alusrca(alusrca[0]), .alusrcb(alusrcb[0]), .pcsrc(pcsrc[0]),
    .alucontrol(alucontrol[0]), .sign(sign[0]), .illegal(illegal[0]), .state(state[0])
  );

  mc_controller #(.MEM_WAIT(1'b1)) u_dut1 (
    .clk(clk), .reset(reset[1]), .opcode(opcode[1]), .funct(funct[1]),
    .zero(zero[1]), .mem_ready(mem_ready[1]), .pcen(pcen[1]), .irwrite(irwrite[1]),
    .iord(iord[1]), .memwrite(memwrite[1]), .regwrite(regwrite[1]), .regdst(regdst[1]),
    .memtoreg(memtoreg[1]), .alusrca(alusrca[1]), .alusrcb(alusrcb[1]), .pcsrc(pcsrc[1]),
    .alucontrol(alucontrol[1]), .sign(sign[1]), .illegal(illegal[1]), .state(state[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Instruction classes: 0 lw, 1 sw, 2 R, 3 imm, 4 branch, 5 jump, 6 illegal.
  int seq_len [7] = '{5, 4, 4, 4, 3, 3, 2};
  int seq     [7][5] = '{'{0, 1, 2, 3, 4}, '{0, 1, 2, 5, 0}, '{0, 1, 6, 7, 0},
                         '{0, 1, 9, 10, 0}, '{0, 1, 8, 0, 0}, '{0, 1, 11, 0, 0},
                         '{0, 1, 0, 0, 0}};

  function automatic int class_of(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'b100011: return 0;
      6'b101011: return 1;
      6'b000000: return (fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010}) ? 2 : 6;
      6'b001000, 6'b001010, 6'b001100, 6'b001101: return 3;
      6'b000100, 6'b000101: return 4;
      6'b000010: return 5;
      default: return 6;
    endcase
  endfunction

  function automatic logic [2:0] r_alu(input logic [5:0] fn);
    case (fn)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  function automatic logic [2:0] i_alu(input logic [5:0] op);
    case (op)
      6'b001010: return 3'b111;
      6'b001100: return 3'b000;
      6'b001101: return 3'b001;
      default:   return 3'b010;
    endcase
  endfunction

  int  step  [2] = '{0, 0};
  int  cls   [2] = '{6, 6};
  bit  known [2] = '{1'b0, 1'b0};

  logic [5:0] op_pool [12] = '{6'b100011, 6'b101011, 6'b000000, 6'b000000, 6'b000100,
                                6'b000101, 6'b001000, 6'b001010, 6'b001100, 6'b001101,
                                6'b000010, 6'b111111};
  logic [5:0] fn_pool [7]  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010,
                                6'b000000, 6'b111000};

  initial begin
    for (int m = 0; m < 2; m++) begin
      reset[m] = 1'b1; opcode[m] = 6'b0; funct[m] = 6'b0;
      zero[m] = 1'b0; mem_ready[m] = 1'b1;
    end

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        reset[m]     = (cyc < 2) || ($urandom_range(0, 59) == 0);
        zero[m]      = 1'($urandom_range(0, 1));
        mem_ready[m] = (cyc < 3) ? 1'b1 : ($urandom_range(0, 2) != 0);
        // Instruction fields only change while fetching, like a real IR.
        if (step[m] == 0) begin
          opcode[m] = op_pool[$urandom_range(0, 11)];
          funct[m]  = fn_pool[$urandom_range(0, 6)];
          if ($urandom_range(0, 7) == 0) opcode[m] = 6'($urandom);
        end
      end
      #1;
      for (int m = 0; m < 2; m++) begin
        int  s;
        bit  rdy;
        bit  last;
        logic [4:0] e_en;
        logic [7:0] e_path;
        logic [2:0] e_alu;
        rdy = mem_ready[m] || (m == 0);
        if (step[m] == 1) cls[m] = class_of(opcode[m], funct[m]);
        s = seq[cls[m]][step[m]];

        e_en = 5'b0; e_path = 8'b0; e_alu = 3'b010;
        if (!reset[m]) begin
          // e_en = {pcen, irwrite, memwrite, regwrite, illegal}
          // e_path = {iord, regdst, memtoreg, alusrca, alusrcb, pcsrc}
          case (s)
            0:  begin e_en = {rdy, rdy, 3'b000}; e_path = 8'b0000_01_00; end
            1:  begin e_en = {4'b0000, cls[m] == 6}; e_path = 8'b0000_11_00; end
            2:  e_path = 8'b0001_10_00;
            3:  e_path = 8'b1000_00_00;
            4:  begin e_en = 5'b00010; e_path = 8'b0010_00_00; end
            5:  begin e_en = 5'b00100; e_path = 8'b1000_00_00; end
            6:  begin e_path = 8'b0001_00_00; e_alu = r_alu(funct[m]); end
            7:  begin e_en = 5'b00010; e_path = 8'b0100_00_00; end
            8:  begin
                  e_en = {zero[m] ^ (opcode[m] == 6'b000101), 4'b0000};
                  e_path = 8'b0001_00_01; e_alu = 3'b110;
                end
            9:  begin e_path = 8'b0001_10_00; e_alu = i_alu(opcode[m]); end
            10: e_en = 5'b00010;
            11: begin e_en = 5'b10000; e_path = 8'b0000_00_10; end
            default: ;
          endcase
        end

        if (known[m]) check($sformatf("state%0d", m), 32'(state[m]), 32'(s));
        check($sformatf("enables%0d", m),
              32'({pcen[m], irwrite[m], memwrite[m], regwrite[m], illegal[m]}), 32'(e_en));
        check($sformatf("alu%0d", m), 32'(alucontrol[m]), 32'(e_alu));
        if (!reset[m]) begin
          check($sformatf("path%0d", m),
                32'({iord[m], regdst[m], memtoreg[m], alusrca[m], alusrcb[m], pcsrc[m]}),
                32'(e_path));
          check($sformatf("sign%0d", m), 32'(sign[m]),
                32'(!(opcode[m] == 6'b001100 || opcode[m] == 6'b001101)));
        end

        // Advance the model: waits hold on memory states, reset restarts.
        last = (step[m] + 1 >= seq_len[cls[m]]);
        if (reset[m]) begin
          step[m] = 0; known[m] = 1'b1;
        end else if ((s == 0 || s == 3 || s == 5) && !rdy) begin
          step[m] = step[m];
        end else if (step[m] == 0) begin
          step[m] = 1;
        end else begin
          step[m] = last ? 0 : step[m] + 1;
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
# mc_controller

Multicycle MIPS control unit: a Moore FSM that sequences each instruction over 3–5 clocks and drives the shared-ALU/shared-memory datapath. It generalises the single-cycle decoder with:
- immediate logic ops: andi, ori, slti;
- bne;
- an illegal-instruction flag;
- an optional memory-ready handshake, so fetch and data accesses can stall on slow memory.

Sits between the instruction register (opcode/funct) and the multicycle datapath muxes and enables.

## Interface
- MEM_WAIT, 0, 1 = FETCH/MEMRD/MEMWR wait for mem_ready; 0 = mem_ready ignored, treated as 1
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access completes this cycle
- pcen  out  1  PC register enable = pcwrite | (branch & (zero ^ branchne))
- irwrite  out  1  IR load enable
- iord  out  1  0 = PC addresses memory, 1 = ALUOut addresses memory
- memwrite  out  1  data memory write strobe
- regwrite  out  1  register file write enable
- regdst  out  1  1 = rd, 0 = rt
- memtoreg  out  1  1 = Data reg, 0 = ALUOut
- alusrca  out  1  0 = PC, 1 = register A
- alusrcb  out  2  00 = B, 01 = constant 4, 10 = extended immediate, 11 = extended immediate << 2
- pcsrc  out  2  00 = ALUResult, 01 = ALUOut, 10 = jump target
- alucontrol  out  3  000 and, 001 or, 010 add, 110 sub, 111 slt
- sign  out  1  1 = sign-extend imm16, 0 = zero-extend
- illegal  out  1  one-cycle pulse, unsupported instruction discarded
- state  out  4  current state encoding, for debug

## Operation
- Opcodes: R 000000, lw 100011, sw 101011, beq 000100, bne 000101, addi 001000, slti 001010, andi 001100, ori 001101, j 000010.
- R-type funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
- Outputs not listed for a state are 0, except alucontrol = 010 (add).
- States and outputs:
  - FETCH(0): iord=0, alusrca=0, alusrcb=01, pcsrc=00, irwrite=pcen=ready.
  - DECODE(1): alusrca=0, alusrcb=11.
  - MEMADR(2): alusrca=1, alusrcb=10.
  - MEMRD(3): iord=1.
  - MEMWB(4): regwrite=1, memtoreg=1, regdst=0.
  - MEMWR(5): iord=1, memwrite=1 (held until ready).
  - RTEX(6): alusrca=1, alusrcb=00, alucontrol from funct.
  - RTWB(7): regwrite=1, regdst=1, memtoreg=0.
  - BRANCH(8): alusrca=1, alusrcb=00, alucontrol=110, pcsrc=01, pcen=zero^branchne (branchne=1 for bne).
  - IMMEX(9): alusrca=1, alusrcb=10, alucontrol = 010 addi / 111 slti / 000 andi / 001 ori.
  - IMMWB(10): regwrite=1, regdst=0, memtoreg=0.
  - JUMP(11): pcsrc=10, pcen=1.
- Here ready = mem_ready | ~MEM_WAIT.
- sign=0 for andi/ori, 1 otherwise; it is decoded combinationally from opcode in every state.
- Transitions:
  - FETCH→DECODE when ready, else hold.
  - DECODE→MEMADR (lw/sw), RTEX, BRANCH (beq/bne), IMMEX (addi/slti/andi/ori), JUMP (j). Unsupported opcode, or R-type with unsupported funct → FETCH with illegal=1 for that DECODE cycle.
  - MEMADR→MEMRD (lw) / MEMWR (sw).
  - MEMRD→MEMWB when ready, else hold.
  - MEMWR→FETCH when ready, else hold.
  - RTEX→RTWB; IMMEX→IMMWB.
  - MEMWB, RTWB, IMMWB, BRANCH, JUMP → FETCH.
- Unused encodings 12–15 → FETCH next cycle, all enables 0, illegal=0.

## Timing
- Reset: state=FETCH the cycle after reset is sampled high. While in reset, all enables and illegal are 0 and alucontrol=010.
- Reset mid-instruction: the pending write is dropped, no regwrite/memwrite is issued, and execution restarts at FETCH.
- Outputs are combinational from state (plus opcode/funct/zero/mem_ready where noted); there is no output register.
- Cycle counts with MEM_WAIT=0: lw 5, sw 4, R-type 4, imm 4, beq/bne 3, j 3. Each wait cycle adds 1.
- Handshake: a memory access completes in the cycle mem_ready=1.
  - irwrite/pcen in FETCH are asserted only in that cycle.
  - memwrite stays high through every MEMWR wait cycle.
  - mem_ready outside FETCH/MEMRD/MEMWR is ignored.
- Branch: pcen in BRANCH depends on zero in the same cycle. No pcen/regwrite/memwrite in DECODE.

## Test plan
- Reset: hold reset 2 cycles with mem_ready=1 → state=0, irwrite=pcen=regwrite=memwrite=0; first post-reset cycle irwrite=pcen=1, alusrcb=01.
- lw (100011), MEM_WAIT=0 → state 0,1,2,3,4,0; regwrite=1 only in state 4 with memtoreg=1, regdst=0; iord=1 only in state 3.
- beq with zero=1 → pcen=1, pcsrc=01 in BRANCH. bne with zero=1 → pcen=0. bne with zero=0 → pcen=1. Each takes 3 cycles.
- ori (001101) → sign=0, IMMEX alucontrol=001, IMMWB regwrite=1, regdst=0. slti → sign=1, alucontrol=111.
- MEM_WAIT=1, sw, mem_ready low 3 cycles in MEMWR → memwrite=1 for 4 consecutive cycles, then FETCH. mem_ready low 2 cycles in FETCH → irwrite stays 0 until ready, then DECODE.
- Illegal opcode 111111, or R-type funct 000000 → illegal=1 for exactly one cycle in DECODE, then FETCH, no regwrite. Reset asserted in RTEX → next state FETCH, no RTWB write.
